// File: rtl/jtopl_pg_pkg.sv
// Shared constants for the phase generator: default widths, MUL factor table
// (half-unit resolution) and the increment scaling helper.
package jtopl_pg_pkg;

    localparam int unsigned NSLOTS_DEF = 18;
    localparam int unsigned PW_DEF     = 19;
    localparam int unsigned FW_DEF     = 17;
    localparam int unsigned OPW_DEF    = 10;
    localparam int unsigned SW_DEF     = 5;
    localparam int unsigned MUL_W      = 4;
    localparam int unsigned FACT_W     = 5;
    localparam int unsigned PROD_W     = FW_DEF + FACT_W;

    // MUL register to factor, in units of 0.5
    localparam logic [FACT_W-1:0] FACTOR [16] = '{
        5'd1,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
        5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30
    };

    function automatic logic [PROD_W-1:0] pg_scale(input logic [FW_DEF-1:0] phinc,
                                                   input logic [MUL_W-1:0]  mul);
        return PROD_W'(phinc) * PROD_W'(FACTOR[mul]);
    endfunction

endpackage

// File: rtl/jtopl_pg_chan_if.sv
// Slot-side bus of the phase generator: per-slot inputs in, operator phase out.
interface jtopl_pg_chan_if #(
    parameter int unsigned PW  = 19,
    parameter int unsigned FW  = 17,
    parameter int unsigned OPW = 10,
    parameter int unsigned SW  = 5
);
    logic           cen;
    logic           slot_sync;
    logic [3:0]     mul;
    logic [FW-1:0]  phinc_pure;
    logic           pg_rst;
    logic [SW-1:0]  cur_slot;
    logic [OPW-1:0] phase_op;
    logic [PW-1:0]  phase_out;
    logic [SW-1:0]  op_slot;
    logic           op_valid;

    modport master (
        output cen, slot_sync, mul, phinc_pure, pg_rst,
        input  cur_slot, phase_op, phase_out, op_slot, op_valid
    );

    modport slave (
        input  cen, slot_sync, mul, phinc_pure, pg_rst,
        output cur_slot, phase_op, phase_out, op_slot, op_valid
    );
endinterface

// File: rtl/jtopl_pg_mem.sv
// Per-slot phase accumulator storage: one combinational read port, one
// synchronous write port, cleared asynchronously on reset.
module jtopl_pg_mem #(
    parameter int unsigned NSLOTS = 18,
    parameter int unsigned PW     = 19,
    parameter int unsigned SW     = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] rd_addr_i,
    output logic [PW-1:0] rd_data_c_o,
    input  logic          we_i,
    input  logic [SW-1:0] wr_addr_i,
    input  logic [PW-1:0] wr_data_i
);
    logic [PW-1:0] mem_q [NSLOTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NSLOTS); i++) mem_q[i] <= '0;
        end else if (we_i && (wr_addr_i < SW'(NSLOTS))) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_c_o = '0;
        if (rd_addr_i < SW'(NSLOTS)) rd_data_c_o = mem_q[rd_addr_i];
    end

endmodule

// File: rtl/jtopl_pg_chan.sv
// Time-multiplexed phase generator: round-robin slot counter, stage 1 scales the
// increment and fetches the stored phase, stage 2 accumulates and writes back.
module jtopl_pg_chan
    import jtopl_pg_pkg::*;
#(
    parameter int unsigned NSLOTS = NSLOTS_DEF,
    parameter int unsigned PW     = PW_DEF,
    parameter int unsigned FW     = FW_DEF,
    parameter int unsigned OPW    = OPW_DEF,
    parameter int unsigned SW     = SW_DEF
) (
    input logic            clk,
    input logic            rst_n,
    jtopl_pg_chan_if.slave pg
);
    localparam int unsigned PRW = FW + FACT_W;

    logic [SW-1:0]  slot_cnt_q, eff_slot_c, slot_nxt_c;
    logic           s1_vld_q, s1_rst_q;
    logic [SW-1:0]  s1_slot_q;
    logic [PRW-1:0] s1_prod_q;
    logic [PW-1:0]  s1_ph_q, rd_ph_c, nxt_c;
    logic [PW-1:0]  phase_out_q;
    logic [OPW-1:0] phase_op_q;
    logic [SW-1:0]  op_slot_q;
    logic           op_valid_q, wr_en_c;

    // slot_sync overrides the counter so the current tick is slot 0
    always_comb begin
        eff_slot_c = (pg.cen && pg.slot_sync) ? '0 : slot_cnt_q;
        slot_nxt_c = (eff_slot_c == SW'(NSLOTS - 1)) ? '0 : eff_slot_c + SW'(1);
        nxt_c      = s1_rst_q ? '0 : s1_ph_q + s1_prod_q[PW:1];
        wr_en_c    = pg.cen && s1_vld_q;
    end

    jtopl_pg_mem #(.NSLOTS(NSLOTS), .PW(PW), .SW(SW)) u_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr_i   (eff_slot_c),
        .rd_data_c_o (rd_ph_c),
        .we_i        (wr_en_c),
        .wr_addr_i   (s1_slot_q),
        .wr_data_i   (nxt_c)
    );

    // Slot counter and stage 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            s1_vld_q   <= 1'b0;
            s1_rst_q   <= 1'b0;
            s1_slot_q  <= '0;
            s1_prod_q  <= '0;
            s1_ph_q    <= '0;
        end else if (pg.cen) begin
            slot_cnt_q <= slot_nxt_c;
            s1_vld_q   <= 1'b1;
            s1_rst_q   <= pg.pg_rst;
            s1_slot_q  <= eff_slot_c;
            s1_prod_q  <= PRW'(pg_scale(FW_DEF'(pg.phinc_pure), pg.mul));
            s1_ph_q    <= rd_ph_c;
        end
    end

    // Stage 2 output registers; op_valid is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_out_q <= '0;
            phase_op_q  <= '0;
            op_slot_q   <= '0;
            op_valid_q  <= 1'b0;
        end else if (wr_en_c) begin
            phase_out_q <= nxt_c;
            phase_op_q  <= nxt_c[PW-1 -: OPW];
            op_slot_q   <= s1_slot_q;
            op_valid_q  <= 1'b1;
        end
    end

    assign pg.cur_slot  = eff_slot_c;
    assign pg.phase_out = phase_out_q;
    assign pg.phase_op  = phase_op_q;
    assign pg.op_slot   = op_slot_q;
    assign pg.op_valid  = op_valid_q;

endmodule

// File: tb/tb_jtopl_pg_chan.sv
// Scoreboard bench for jtopl_pg_chan: driver pushes expected per-slot phases,
// a monitor pops and compares each output produced on a cen tick.
module tb_jtopl_pg_chan;
    localparam int NS = 18;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jtopl_pg_chan_if ifc ();

    jtopl_pg_chan dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pg    (ifc)
    );

    typedef struct {
        int slot;
        int ph;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   acc_m[NS];
    int   last_ph[NS];
    int   last_op[NS];
    int   last_slot;
    int   slot_m;
    int   fac[16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one tick's inputs; on a cen tick, model the slot and queue the result
    task automatic tick(input bit c, input bit sync, input int mul, input int phinc,
                        input bit prst);
        int nxt;
        @(negedge clk);
        ifc.cen        = c;
        ifc.slot_sync  = sync;
        ifc.mul        = 4'(mul);
        ifc.phinc_pure = 17'(phinc);
        ifc.pg_rst     = prst;
        if (c) begin
            if (sync) slot_m = 0;
            #1;
            check("cur_slot", longint'(ifc.cur_slot), longint'(slot_m));
            nxt = prst ? 0 : ((acc_m[slot_m] + ((phinc * fac[mul]) >> 1)) & 'h7FFFF);
            acc_m[slot_m] = nxt;
            sbq.push_back('{slot_m, nxt});
            slot_m = (slot_m + 1) % NS;
        end
    endtask

    task automatic pass(input int mul, input int phinc, input int rst_slot);
        for (int i = 0; i < NS; i++) tick(1'b1, 1'b0, mul, phinc, slot_m == rst_slot);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        ifc.cen       = 1'b0;
        ifc.slot_sync = 1'b0;
        ifc.pg_rst    = 1'b0;
        sbq.delete();
        for (int i = 0; i < NS; i++) acc_m[i] = 0;
        slot_m = 0;
        #1;
        check("rst phase_out", longint'(ifc.phase_out), 0);
        check("rst phase_op", longint'(ifc.phase_op), 0);
        check("rst op_slot", longint'(ifc.op_slot), 0);
        check("rst op_valid", longint'(ifc.op_valid), 0);
        check("rst cur_slot", longint'(ifc.cur_slot), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: each cen edge after the first post-reset tick yields one output
    always @(posedge clk) begin
        bit c;
        c = ifc.cen && rst_n;
        #1;
        if (c && rst_n && ifc.op_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard: unexpected output slot %0d phase 0x%0h, nothing expected",
                         ifc.op_slot, ifc.phase_out);
            end else begin
                e = sbq.pop_front();
                check("op_slot", longint'(ifc.op_slot), longint'(e.slot));
                check("phase_out", longint'(ifc.phase_out), longint'(e.ph));
                check("phase_op", longint'(ifc.phase_op), longint'(e.ph >> 9));
            end
            last_slot = int'(ifc.op_slot);
            if (int'(ifc.op_slot) < NS) begin
                last_ph[ifc.op_slot] = int'(ifc.phase_out);
                last_op[ifc.op_slot] = int'(ifc.phase_op);
            end
        end
    end

    initial begin
        rst_n          = 1'b1;
        ifc.cen        = 1'b0;
        ifc.slot_sync  = 1'b0;
        ifc.mul        = '0;
        ifc.phinc_pure = '0;
        ifc.pg_rst     = 1'b0;
        #2;
        do_reset();

        // 1: base increment, two-tick latency, three passes
        tick(1'b1, 1'b0, 1, 'h100, 1'b0);
        settle();
        check("t1 no output after first tick", longint'(ifc.op_valid), 0);
        tick(1'b1, 1'b0, 1, 'h100, 1'b0);
        settle();
        check("t1 op_valid after second tick", longint'(ifc.op_valid), 1);
        check("t1 first op_slot", longint'(ifc.op_slot), 0);
        for (int i = 2; i < NS; i++) tick(1'b1, 1'b0, 1, 'h100, 1'b0);
        pass(1, 'h100, -1);
        pass(1, 'h100, -1);
        tick(1'b1, 1'b0, 1, 'h100, 1'b0);
        settle();
        check("t1 slot17 phase_out", longint'(last_ph[17]), 'h300);
        check("t1 slot0 phase_op", longint'(last_op[0]), 1);

        // 2: half factor, then factor 30
        do_reset();
        pass(0, 'h100, -1);
        check("t2 mul0 slot0", longint'(last_ph[0]), 'h080);
        pass(15, 'h100, -1);
        check("t2 mul15 slot0", longint'(last_ph[0]), 'hF80);

        // 3: max increment with factor 30, accumulator wrap
        do_reset();
        pass(15, 'h1FFFF, -1);
        check("t3 one pass slot3", longint'(last_ph[3]), 'h5FFF1);
        pass(15, 'h1FFFF, -1);
        check("t3 wrap slot3", longint'(last_ph[3]), 'h3FFE2);

        // 4: slot 5 held in phase reset
        do_reset();
        pass(1, 'h40, 5);
        pass(1, 'h40, 5);
        check("t4 slot5 held", longint'(last_ph[5]), 0);
        check("t4 slot4", longint'(last_ph[4]), 'h80);

        // 5: slot_sync at slot 9 restarts the round at slot 0
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 1, 'h40, 1'b0);
        tick(1'b1, 1'b1, 1, 'h40, 1'b0);
        tick(1'b1, 1'b0, 1, 'h40, 1'b0);
        settle();
        check("t5 op_slot after sync", longint'(last_slot), 0);
        check("t5 slot0 phase", longint'(last_ph[0]), 'h100);

        // 6: sparse cen, then reset mid-pass
        for (int i = 0; i < 30; i++) tick(i % 3 == 0, 1'b0, 1, 'h40, 1'b0);
        @(negedge clk);
        #3;
        do_reset();
        tick(1'b1, 1'b0, 0, 0, 1'b0);
        tick(1'b1, 1'b0, 0, 0, 1'b0);
        settle();
        check("t6 first post-reset op_slot", longint'(ifc.op_slot), 0);
        check("t6 first post-reset phase", longint'(ifc.phase_out), 0);
        for (int i = 2; i < NS; i++) tick(1'b1, 1'b0, 0, 0, 1'b0);
        tick(1'b1, 1'b0, 0, 0, 1'b0);
        settle();
        check("t6 slot17 cleared", longint'(last_ph[17]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
